// File: rtl/simd_mem_pkg.sv
// Shared definitions for the vector BRAM read path: default sizes, address type
// and the read sequencer state encoding.
package simd_mem_pkg;
  localparam int DATA_WIDTH_DEF = 128;
  localparam int DEPTH_DEF      = 256;
  localparam int ADDR_W_DEF     = $clog2(DEPTH_DEF);

  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready beat stream with a last-beat marker, produced by bram_stream_reader.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/stream_buf2.sv
// Two-entry register FIFO with valid/ready output; head entry drives the output
// directly and the occupancy is exported for the upstream issue decision.
module stream_buf2 #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   occupancy
);
  logic [W-1:0] tail;
  logic         pop;

  assign valid = (occupancy != 2'd0);
  assign pop   = valid & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= 2'd0;
      data      <= '0;
      tail      <= '0;
    end else begin
      occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        // Full with simultaneous push: tail moves to head, new word takes the tail.
        if (occupancy == 2'd2) begin
          data <= tail;
          if (push) tail <= push_data;
        end else if (push) begin
          data <= push_data;
        end
      end else if (push) begin
        if (occupancy == 2'd0) data <= push_data;
        else                   tail <= push_data;
      end
    end
  end
endmodule

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read sequencer presenting words as a valid/ready stream.
// Optional macro BRAM_RD_STRIDE_EN adds a latched address stride input.
module bram_stream_reader
  import simd_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       count,
`ifdef BRAM_RD_STRIDE_EN
  input  logic [ADDR_W-1:0]     stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     bram_addr,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  bram_stream_reader_if.master  m
);
  rd_state_e               state;
  logic [ADDR_W-1:0]       rd_ptr, addr_hold, step;
  logic [ADDR_W:0]         issue_cnt, beat_cnt;
  logic                    inflight, last_inflight, zero_done;
  logic                    issue, pop, buf_valid;
  logic [1:0]              occ;
  logic [2:0]              load;
  logic [DATA_WIDTH:0]     buf_data;

`ifdef BRAM_RD_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  assign pop  = buf_valid & m.m_ready;
  // A read may only issue if its word is guaranteed a free slot on arrival.
  assign load  = {1'b0, occ} + {2'b0, inflight};
  assign issue = (state == ISSUE) && (load < (3'd2 + {2'b0, pop}));

  assign bram_addr = issue ? rd_ptr : addr_hold;
  assign bram_we   = 1'b0;
  assign busy      = (state != IDLE) | zero_done;
  assign done      = zero_done | ((state == DRAIN) && pop && (beat_cnt == (ADDR_W+1)'(1)));

  assign m.m_valid = buf_valid;
  assign m.m_data  = buf_data[DATA_WIDTH-1:0];
  assign m.m_last  = buf_data[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      addr_hold     <= '0;
      issue_cnt     <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      last_inflight <= 1'b0;
      zero_done     <= 1'b0;
`ifdef BRAM_RD_STRIDE_EN
      stride_q      <= '0;
`endif
    end else begin
      addr_hold     <= bram_addr;
      inflight      <= issue;
      last_inflight <= issue && (issue_cnt == (ADDR_W+1)'(1));
      zero_done     <= 1'b0;
      if (pop) beat_cnt <= beat_cnt - (ADDR_W+1)'(1);
      unique case (state)
        IDLE: begin
          if (start && !zero_done) begin
            if (count != '0) begin
              state     <= ISSUE;
              rd_ptr    <= base_addr;
              issue_cnt <= count;
              beat_cnt  <= count;
`ifdef BRAM_RD_STRIDE_EN
              stride_q  <= stride;
`endif
            end else begin
              zero_done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            rd_ptr    <= rd_ptr + step;
            issue_cnt <= issue_cnt - (ADDR_W+1)'(1);
            if (issue_cnt == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (beat_cnt == (ADDR_W+1)'(1))) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_buf2 #(.W(DATA_WIDTH + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({last_inflight, bram_rdata}),
    .ready     (m.m_ready),
    .valid     (buf_valid),
    .data      (buf_data),
    .occupancy (occ)
  );
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed/randomized bench for bram_stream_reader against a queue-based beat model.
module tb_bram_stream_reader;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    base_addr = '0;
  logic [8:0]    count = '0;
  logic [7:0]    stride = 8'd1;
  logic          busy, done, bram_we;
  logic [7:0]    bram_addr;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] mem [256];

  int total = 0;
  int bad   = 0;

  bram_stream_reader_if #(.DATA_WIDTH(DW)) s ();

  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
`ifdef BRAM_RD_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_rdata (bram_rdata),
    .m          (s)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM: data appears the cycle after the address.
  always @(posedge clk) bram_rdata <= mem[bram_addr];

  task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command: expected beats are mem[(base + i*strd) mod 256], last on i == cnt-1.
  task automatic run(input logic [7:0] base, input logic [8:0] cnt, input logic [7:0] strd,
                     input bit rnd_ready, input int abort_after, input bit chk_timing,
                     input bit inject);
    logic [DW:0] exp_q[$];
    logic [DW:0] e;
    logic [DW-1:0] prev_data;
    logic prev_last, stall_prev, got_done;
    int beats;
    for (int i = 0; i < int'(cnt); i++)
      exp_q.push_back({(i == int'(cnt) - 1), mem[(int'(base) + i * int'(strd)) % 256]});
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; count = cnt; stride = strd;
    s.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    got_done = 1'b0; stall_prev = 1'b0; beats = 0; prev_data = '0; prev_last = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (chk_timing) begin
        check($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 6));
        check($sformatf("valid_c%0d", c), s.m_valid, (c >= 3 && c <= 6));
        check($sformatf("done_c%0d", c), done, (c == 6));
        if (c == 1) check("addr_c1", bram_addr, base);
      end
      check("we_zero", bram_we, 1'b0);
      if (stall_prev) begin
        check("stall_data", s.m_data, prev_data);
        check("stall_last", s.m_last, prev_last);
      end
      if (s.m_valid && s.m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d_data", beats), s.m_data, e[DW-1:0]);
          check($sformatf("beat%0d_last", beats), s.m_last, e[DW]);
        end
        beats++;
      end
      if (done) begin
        check("done_after_all_beats", exp_q.size(), 0);
        check("done_not_aborted", abort_after, -1);
        got_done = 1'b1;
      end
      stall_prev = s.m_valid && !s.m_ready;
      prev_data = s.m_data; prev_last = s.m_last;
      if (abort_after >= 0 && beats == abort_after) begin
        rst = 1'b1; #1;
        check("abort_valid", s.m_valid, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        return;
      end
      if (got_done) break;
      @(posedge clk); #1;
      start = inject && (c == 1);
      if (inject && c == 1) begin base_addr = base ^ 8'h55; count = 9'd3; end
      if (rnd_ready) s.m_ready = 1'($urandom_range(0, 1));
    end
    check("done_seen", got_done, 1'b1);
    check("beats_left", exp_q.size(), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after", busy, 1'b0);
    check("done_single", done, 1'b0);
    check("valid_after", s.m_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    s.m_ready = 1'b1;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", s.m_valid, 1'b0);
    check("rst_last", s.m_last, 1'b0);
    check("rst_data", s.m_data, '0);
    check("rst_addr", bram_addr, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    run(8'h10, 9'd4, 8'd1, 1'b0, -1, 1'b1, 1'b0);
    run(8'hFE, 9'd4, 8'd1, 1'b0, -1, 1'b0, 1'b0);
    run(8'h20, 9'd8, 8'd1, 1'b1, -1, 1'b0, 1'b0);
    run(8'h33, 9'd0, 8'd1, 1'b0, -1, 1'b0, 1'b0);
    run(8'h40, 9'd6, 8'd1, 1'b1, -1, 1'b0, 1'b1);
    run(8'h80, 9'd10, 8'd1, 1'b1, 3, 1'b0, 1'b0);
    run(8'h05, 9'd2, 8'd1, 1'b0, -1, 1'b0, 1'b0);
    run(8'hC7, 9'd256, 8'd1, 1'b0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run(8'($urandom), 9'($urandom_range(1, 20)), 8'd1, 1'b1, -1, 1'b0, 1'b0);
`ifdef BRAM_RD_STRIDE_EN
    run(8'h00, 9'd5, 8'h40, 1'b0, -1, 1'b0, 1'b0);
    run(8'h12, 9'd4, 8'h00, 1'b1, -1, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
